t05_histogram_pipe: RTL and testbench
=====================================

# t05_histogram_pipe

Parametrised symbol-histogram engine for the compression front end. It accepts symbols from the SPI byte stream over a valid/ready handshake and performs a read-modify-write on the per-symbol count in SRAM for each one. It optionally zeroes the whole histogram before a run and stops on a configurable end-of-file symbol. It also reports the total symbol count, a sticky saturation flag and completion status to the controller while `en_state` selects the histogram phase.

## Interface
Parameters:
- `SYM_W`, 8, symbol width; histogram depth is 2^SYM_W bins
- `CNT_W`, 32, bin and total counter width
- `RD_LAT`, 2, SRAM read latency in cycles (≥1)
- `EN_CODE`, 4'd1, `en_state` value that enables this block
- `EOF_SYM`, 8'h1A, end-of-file symbol (SYM_W bits)

Ports:
- `clk` in 1: clock; single clock domain
- `rst` in 1: asynchronous, active-high reset
- `en_state` in 4: controller phase; block is active only when it equals EN_CODE
- `clear_start` in 1: sampled in IDLE; 1 requests a histogram zeroing pass before accepting symbols
- `sym_valid` in 1: symbol available
- `sym_in` in SYM_W: symbol value
- `sym_ready` out 1: block accepts a symbol this cycle
- `sram_rdata` in CNT_W: SRAM read data
- `sram_addr` out SYM_W: SRAM bin address
- `sram_wdata` out CNT_W: SRAM write data
- `wr_r_en` out 2: SRAM command; 0 = read, 1 = write, 3 = idle
- `total` out CNT_W: symbols counted this run, EOF included
- `busy` out 1: state is not IDLE and not DONE
- `sat` out 1: sticky; a bin or `total` hit its all-ones value
- `eof` out 1: EOF symbol processed
- `complete` out 1: run finished

## Operation
- **States:** IDLE, CLEAR, ACCEPT, RD, WAIT, WR, DONE.
- **Enable gating:** when `en_state != EN_CODE`, all state and registers hold. Outputs are forced to `sym_ready=0` and `wr_r_en=3`; `total`, `sat`, `eof` and `complete` are still driven.
- **IDLE:** all outputs idle.
  - On enable: clear `total`, `sat`, the bin address counter, `eof` and `complete`.
  - Then go to CLEAR if `clear_start=1`, otherwise go to ACCEPT.
- **CLEAR:** one write per cycle.
  - `wr_r_en=1`, `sram_wdata=0`, `sram_addr` = counter, counting 0 upward.
  - After address 2^SYM_W−1, go to ACCEPT.
- **ACCEPT:** `sym_ready=1`.
  - On `sym_valid`, latch `sym_in` and go to RD.
- **RD:** `wr_r_en=0`, `sram_addr` = latched symbol; go to WAIT.
- **WAIT:** `wr_r_en=3` for RD_LAT cycles (down-counter), then go to WR.
- **WR:**
  - Drive `wr_r_en=1`, `sram_addr` = symbol, `sram_wdata = sram_rdata+1`, saturating at all-ones.
  - Increment `total` with saturation.
  - Set `sat` if either saturates.
  - If the symbol is EOF_SYM, go to DONE; otherwise go to ACCEPT.
- **DONE:** `eof=1`, `complete=1` held, `wr_r_en=3`.
  - Stays in DONE while enabled.
  - When `en_state` leaves EN_CODE, go to IDLE. This is the one transition taken while disabled.
- **Arithmetic:** all increments are CNT_W wide and never wrap.
- **Reset:** reset at any time, including mid-CLEAR or mid-RMW, returns the block to IDLE. The in-flight write is abandoned.

## Timing
- **Reset values:** state=IDLE; `sym_ready=0`, `sram_addr=0`, `sram_wdata=0`, `wr_r_en=3`, `total=0`, `busy=0`, `sat=0`, `eof=0`, `complete=0`.
- **Output timing:** outputs are Moore-decoded from registered state. `sram_wdata` in WR is combinational from `sram_rdata`.
- **SRAM contract:** `sram_rdata` is valid RD_LAT cycles after the RD cycle and is held until the next command.
- **Throughput:** one symbol per RD_LAT+3 cycles (ACCEPT, RD, RD_LAT×WAIT, WR). Default is 5 cycles.
- **Handshake:** `sym_ready` is high only in ACCEPT. The transfer occurs on the edge where `sym_valid & sym_ready`. `sym_in` need not be held afterwards.
- **Clear pass:** takes 2^SYM_W cycles; `sym_ready` is first high in the cycle after the last clear write.
- **Status update:** `total` updates on the edge leaving WR. `eof` and `complete` rise on the edge entering DONE.
- **Same-bin writes:** back-to-back identical symbols are safe, because each WR completes before the next RD.

## Test plan
- **Reset check:** assert `rst` mid-WAIT → all outputs match the reset values on the next cycle, and the state is IDLE.
- **Single symbol:** `en_state=1`, send 8'h41 with `sram_rdata=5` → RD addr 0x41 on cycle 2, WR addr 0x41 with wdata 6 on cycle 5, then `total=1`.
- **EOF run:** symbols 0x41, 0x42, 0x1A with `sram_rdata=0` → three writes of 1, then `total=3`, `eof=complete=1` held. Drop `en_state` → IDLE; the next enable clears the flags.
- **Saturation:** `sram_rdata=32'hFFFFFFFF` → `sram_wdata=32'hFFFFFFFF`, `sat=1`, and `sat` stays 1 on the following normal symbols.
- **Clear pass:** `clear_start=1` on enable → 256 consecutive writes of 0 to addresses 0..255, then `sym_ready=1`.
- **Freeze:** drive `en_state=0` for 3 cycles mid-WAIT → `wr_r_en=3` and `sym_ready=0` while held. On resume, WAIT finishes and the write value is correct.

Source files
------------

// File: rtl/t05_histogram_pipe_if.sv
// Symbol stream and SRAM command bus of the histogram engine.
// The engine owns the master side; the symbol source and SRAM sit on the slave side.
interface t05_histogram_pipe_if #(
    parameter int SYM_W = 8,
    parameter int CNT_W = 32
);
    logic             sym_valid;
    logic [SYM_W-1:0] sym_in;
    logic             sym_ready;
    logic [CNT_W-1:0] sram_rdata;
    logic [SYM_W-1:0] sram_addr;
    logic [CNT_W-1:0] sram_wdata;
    logic [1:0]       wr_r_en;

    modport master (
        input  sym_valid, sym_in, sram_rdata,
        output sym_ready, sram_addr, sram_wdata, wr_r_en
    );

    modport slave (
        output sym_valid, sym_in, sram_rdata,
        input  sym_ready, sram_addr, sram_wdata, wr_r_en
    );
endinterface

// File: rtl/t05_histogram_pipe.sv
// Symbol-histogram engine: optional zeroing pass, then one SRAM
// read-modify-write per accepted symbol until the end-of-file symbol.
module t05_histogram_pipe #(
    parameter int               SYM_W   = 8,
    parameter int               CNT_W   = 32,
    parameter int               RD_LAT  = 2,
    parameter logic [3:0]       EN_CODE = 4'd1,
    parameter logic [SYM_W-1:0] EOF_SYM = 8'h1A
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [3:0]           en_state,
    input  logic                 clear_start,
    t05_histogram_pipe_if.master bus,
    output logic [CNT_W-1:0]     total,
    output logic                 busy,
    output logic                 sat,
    output logic                 eof,
    output logic                 complete
);

    localparam int WAIT_W = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

    localparam logic [1:0] CMD_RD   = 2'd0;
    localparam logic [1:0] CMD_WR   = 2'd1;
    localparam logic [1:0] CMD_IDLE = 2'd3;

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        ACCEPT,
        RD,
        WAIT,
        WR,
        DONE
    } state_t;

    state_t            state;
    logic [SYM_W-1:0]  sym_q;
    logic [SYM_W-1:0]  clr_cnt;
    logic [WAIT_W-1:0] wait_cnt;

    logic              en;
    logic [CNT_W-1:0]  bin_inc;
    logic [CNT_W-1:0]  total_inc;

    assign en = (en_state == EN_CODE);

    // Saturating increments for the bin being rewritten and for the running total.
    assign bin_inc   = (&bus.sram_rdata) ? bus.sram_rdata : bus.sram_rdata + CNT_W'(1);
    assign total_inc = (&total) ? total : total + CNT_W'(1);

    // Moore output decode from the registered state; the SRAM command is silenced while disabled.
    always_comb begin
        // NOTE: every output gets a default first so no path leaves it unassigned and infers a latch.
        bus.sym_ready  = 1'b0;
        bus.wr_r_en    = CMD_IDLE;
        bus.sram_addr  = '0;
        bus.sram_wdata = '0;
        busy           = (state != IDLE) && (state != DONE);
        case (state)
            CLEAR: begin
                bus.wr_r_en   = en ? CMD_WR : CMD_IDLE;
                bus.sram_addr = clr_cnt;
            end
            ACCEPT: begin
                bus.sym_ready = en;
            end
            RD: begin
                bus.wr_r_en   = en ? CMD_RD : CMD_IDLE;
                bus.sram_addr = sym_q;
            end
            WR: begin
                bus.wr_r_en    = en ? CMD_WR : CMD_IDLE;
                bus.sram_addr  = sym_q;
                bus.sram_wdata = bin_inc;
            end
            default: ;
        endcase
    end

    // Phase sequencing, symbol latch, wait countdown and run status; everything freezes while disabled.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            sym_q    <= '0;
            clr_cnt  <= '0;
            wait_cnt <= '0;
            total    <= '0;
            sat      <= 1'b0;
            eof      <= 1'b0;
            complete <= 1'b0;
        end else if (!en) begin
            // NOTE: non-blocking assignments here so every register samples pre-edge values.
            if (state == DONE) begin
                state <= IDLE;
            end
        end else begin
            case (state)
                IDLE: begin
                    total    <= '0;
                    sat      <= 1'b0;
                    clr_cnt  <= '0;
                    eof      <= 1'b0;
                    complete <= 1'b0;
                    state    <= clear_start ? CLEAR : ACCEPT;
                end
                CLEAR: begin
                    clr_cnt <= clr_cnt + SYM_W'(1);
                    if (&clr_cnt) begin
                        state <= ACCEPT;
                    end
                end
                ACCEPT: begin
                    if (bus.sym_valid) begin
                        sym_q <= bus.sym_in;
                        state <= RD;
                    end
                end
                RD: begin
                    wait_cnt <= WAIT_W'(RD_LAT - 1);
                    state    <= WAIT;
                end
                WAIT: begin
                    if (wait_cnt == '0) begin
                        state <= WR;
                    end else begin
                        wait_cnt <= wait_cnt - WAIT_W'(1);
                    end
                end
                WR: begin
                    total <= total_inc;
                    if ((&bin_inc) || (&total_inc)) begin
                        sat <= 1'b1;
                    end
                    if (sym_q == EOF_SYM) begin
                        eof      <= 1'b1;
                        complete <= 1'b1;
                        state    <= DONE;
                    end else begin
                        state <= ACCEPT;
                    end
                end
                DONE: begin
                    state <= DONE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_t05_histogram_pipe.sv
// Directed bench for t05_histogram_pipe with default parameters (RD_LAT=2).
module tb_t05_histogram_pipe;

    logic        clk;
    logic        rst;
    logic [3:0]  en_state;
    logic        clear_start;
    logic [31:0] total;
    logic        busy;
    logic        sat;
    logic        eof;
    logic        complete;

    int n_vec;
    int n_err;

    t05_histogram_pipe_if #(.SYM_W(8), .CNT_W(32)) bus ();

    t05_histogram_pipe dut (
        .clk         (clk),
        .rst         (rst),
        .en_state    (en_state),
        .clear_start (clear_start),
        .bus         (bus),
        .total       (total),
        .busy        (busy),
        .sat         (sat),
        .eof         (eof),
        .complete    (complete)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: run did not finish, got timeout required summary");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, ".sym_ready"}, bus.sym_ready, 1'b0);
        check({tag, ".sram_addr"}, bus.sram_addr, 8'h00);
        check({tag, ".sram_wdata"}, bus.sram_wdata, 32'h0);
        check({tag, ".wr_r_en"}, bus.wr_r_en, 2'd3);
        check({tag, ".total"}, total, 32'h0);
        check({tag, ".busy"}, busy, 1'b0);
        check({tag, ".sat"}, sat, 1'b0);
        check({tag, ".eof"}, eof, 1'b0);
        check({tag, ".complete"}, complete, 1'b0);
    endtask

    // Starts in ACCEPT; returns one cycle after the WR cycle.
    task automatic send(input logic [7:0] s, input logic [31:0] rd, input logic [31:0] exp_w);
        string t;
        t = $sformatf("sym%02h", s);
        check({t, ".ready"}, bus.sym_ready, 1'b1);
        bus.sym_valid  = 1'b1;
        bus.sym_in     = s;
        bus.sram_rdata = rd;
        tick();
        bus.sym_valid = 1'b0;
        bus.sym_in    = 8'hFF;
        check({t, ".rd_cmd"}, bus.wr_r_en, 2'd0);
        check({t, ".rd_addr"}, bus.sram_addr, s);
        tick();
        check({t, ".wait1_cmd"}, bus.wr_r_en, 2'd3);
        tick();
        check({t, ".wait2_cmd"}, bus.wr_r_en, 2'd3);
        tick();
        check({t, ".wr_cmd"}, bus.wr_r_en, 2'd1);
        check({t, ".wr_addr"}, bus.sram_addr, s);
        check({t, ".wr_data"}, bus.sram_wdata, exp_w);
        tick();
    endtask

    initial begin
        n_vec          = 0;
        n_err          = 0;
        rst            = 1'b1;
        en_state       = 4'd0;
        clear_start    = 1'b0;
        bus.sym_valid  = 1'b0;
        bus.sym_in     = 8'h00;
        bus.sram_rdata = 32'h0;

        // Reset values
        tick();
        tick();
        check_reset_outputs("reset");
        rst = 1'b0;
        tick();
        check("idle_disabled.ready", bus.sym_ready, 1'b0);
        check("idle_disabled.busy", busy, 1'b0);

        // Single symbol: IDLE cycle 0, ACCEPT cycle 1, RD cycle 2, WR cycle 5
        en_state = 4'd1;
        tick();
        check("single.accept_busy", busy, 1'b1);
        send(8'h41, 32'd5, 32'd6);
        check("single.total", total, 32'd1);
        check("single.sat", sat, 1'b0);

        // Close this run with EOF, then confirm flags survive until re-enable
        send(8'h1A, 32'd0, 32'd1);
        check("run1.total", total, 32'd2);
        check("run1.eof", eof, 1'b1);
        en_state = 4'd0;
        tick();
        check("run1_idle.eof_held", eof, 1'b1);
        check("run1_idle.busy", busy, 1'b0);
        en_state = 4'd1;
        tick();
        check("rearm.total", total, 32'd0);
        check("rearm.eof", eof, 1'b0);
        check("rearm.complete", complete, 1'b0);

        // EOF run
        send(8'h41, 32'd0, 32'd1);
        send(8'h42, 32'd0, 32'd1);
        check("eofrun.mid_eof", eof, 1'b0);
        send(8'h1A, 32'd0, 32'd1);
        check("eofrun.total", total, 32'd3);
        check("eofrun.eof", eof, 1'b1);
        check("eofrun.complete", complete, 1'b1);
        check("eofrun.busy", busy, 1'b0);
        check("eofrun.ready", bus.sym_ready, 1'b0);
        check("eofrun.cmd", bus.wr_r_en, 2'd3);
        tick();
        tick();
        check("eofrun.eof_held", eof, 1'b1);
        check("eofrun.complete_held", complete, 1'b1);
        check("eofrun.total_held", total, 32'd3);
        en_state = 4'd0;
        tick();
        en_state = 4'd1;
        tick();
        check("rearm2.eof", eof, 1'b0);
        check("rearm2.complete", complete, 1'b0);
        check("rearm2.total", total, 32'd0);

        // Saturation and stickiness
        send(8'h10, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        check("sat.flag", sat, 1'b1);
        check("sat.total", total, 32'd1);
        send(8'h11, 32'd7, 32'd8);
        check("sat.sticky", sat, 1'b1);
        check("sat.total2", total, 32'd2);

        // Freeze mid-WAIT
        bus.sym_valid  = 1'b1;
        bus.sym_in     = 8'h22;
        bus.sram_rdata = 32'd9;
        tick();
        bus.sym_valid = 1'b0;
        check("freeze.rd_cmd", bus.wr_r_en, 2'd0);
        tick();
        en_state = 4'd0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check($sformatf("freeze[%0d].cmd", i), bus.wr_r_en, 2'd3);
            check($sformatf("freeze[%0d].ready", i), bus.sym_ready, 1'b0);
            check($sformatf("freeze[%0d].busy", i), busy, 1'b1);
        end
        en_state = 4'd1;
        tick();
        check("freeze.wait2_cmd", bus.wr_r_en, 2'd3);
        tick();
        check("freeze.wr_cmd", bus.wr_r_en, 2'd1);
        check("freeze.wr_addr", bus.sram_addr, 8'h22);
        check("freeze.wr_data", bus.sram_wdata, 32'd10);
        tick();
        check("freeze.total", total, 32'd3);
        check("freeze.ready", bus.sym_ready, 1'b1);

        // Reset mid-WAIT
        bus.sym_valid  = 1'b1;
        bus.sym_in     = 8'h33;
        bus.sram_rdata = 32'd4;
        tick();
        bus.sym_valid = 1'b0;
        tick();
        check("midwait.cmd", bus.wr_r_en, 2'd3);
        check("midwait.busy", busy, 1'b1);
        rst         = 1'b1;
        clear_start = 1'b1;
        tick();
        check_reset_outputs("midwait_reset");

        // Clear pass: 256 writes of zero, then ready
        rst = 1'b0;
        tick();
        for (int i = 0; i < 256; i++) begin
            check($sformatf("clear[%0d]", i),
                  {bus.wr_r_en, bus.sram_addr, bus.sram_wdata, bus.sym_ready},
                  {2'd1, 8'(i), 32'd0, 1'b0});
            tick();
        end
        clear_start = 1'b0;
        check("clear.done_ready", bus.sym_ready, 1'b1);
        check("clear.done_cmd", bus.wr_r_en, 2'd3);
        check("clear.total", total, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
